// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and types for the single-master interconnect.
package ahb_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } def_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_SLV  = 2'b01,
    OWN_DEF  = 2'b10
  } owner_e;

  function automatic logic is_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahblite_default_slave.sv
// Built-in default slave: produces the two-cycle AHB ERROR response.
// Used both for unmapped addresses and for watchdog aborts of a hung slave.
module ahblite_default_slave
  import ahb_pkg::*;
(
  input  logic HCLK,
  input  logic HRESETn,
  input  logic start,
  input  logic HREADY,
  output logic HREADYOUT,
  output logic HRESP
);

  def_state_e r_state;
  def_state_e w_state_next;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= DS_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    HREADYOUT    = 1'b1;
    HRESP        = HRESP_OKAY;
    unique case (r_state)
      DS_IDLE: begin
        if (start) w_state_next = DS_ERR1;
      end
      DS_ERR1: begin
        HREADYOUT    = 1'b0;
        HRESP        = HRESP_ERROR;
        w_state_next = DS_ERR2;
      end
      DS_ERR2: begin
        HRESP = HRESP_ERROR;
        // a new unmapped access accepted in the final error cycle chains straight on
        w_state_next = (start && HREADY) ? DS_ERR1 : DS_IDLE;
      end
      default: w_state_next = DS_IDLE;
    endcase
  end

endmodule

// File: rtl/ahblite_bus_n.sv
// AHB-Lite single-master interconnect: address decode, data-phase return mux,
// default error slave and per-transfer stall watchdog.
module ahblite_bus_n
  import ahb_pkg::*;
#(
  parameter int NUM_SLAVES = 5,
  parameter int DEC_MSB    = 31,
  parameter int DEC_LSB    = 24,
  parameter logic [NUM_SLAVES*(DEC_MSB-DEC_LSB+1)-1:0] SLAVE_BASES =
    {8'h40, 8'h30, 8'h20, 8'h10, 8'h00},
  parameter int TIMEOUT    = 256
) (
  input  logic                         HCLK,
  input  logic                         HRESETn,
  input  logic [31:0]                  HADDR,
  input  logic [1:0]                   HTRANS,
  output logic                         HREADY,
  output logic [31:0]                  HRDATA,
  output logic                         HRESP,
  output logic [NUM_SLAVES-1:0]        HSEL_S,
  input  logic [NUM_SLAVES-1:0]        HREADY_S,
  input  logic [NUM_SLAVES*32-1:0]     HRDATA_S,
  input  logic [NUM_SLAVES-1:0]        HRESP_S,
  output logic                         to_flag,
  output logic [3:0]                   to_slave,
  input  logic                         to_clr
);

  localparam int FW = DEC_MSB - DEC_LSB + 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  owner_e          r_owner;
  logic [3:0]      r_idx;
  logic [CW-1:0]   r_wd_cnt;
  logic            r_to_flag;
  logic [3:0]      r_to_slave;

  logic [FW-1:0]         w_field;
  logic [NUM_SLAVES-1:0] w_match;
  logic [NUM_SLAVES-1:0] w_hsel;
  logic [3:0]            w_dec_idx;
  logic                  w_dec_hit;
  logic                  w_active;
  logic                  w_slv_ready;
  logic                  w_slv_resp;
  logic [DATA_W-1:0]     w_slv_rdata;
  logic                  w_def_ready;
  logic                  w_def_resp;
  logic                  w_def_start;
  logic                  w_stall;
  logic                  w_abort;
  logic                  w_unused;

  assign w_field  = HADDR[DEC_MSB:DEC_LSB];
  assign w_active = is_active(HTRANS);
  assign w_unused = ^HADDR;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_dec
      assign w_match[gi] = (w_field == SLAVE_BASES[gi*FW +: FW]);
    end
  endgenerate

  // descending scan so the lowest matching index ends up owning the select
  always_comb begin
    w_hsel    = '0;
    w_dec_idx = '0;
    w_dec_hit = 1'b0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_hsel    = '0;
        w_hsel[i] = 1'b1;
        w_dec_idx = 4'(i);
        w_dec_hit = 1'b1;
      end
    end
  end

  assign HSEL_S = w_hsel;

  always_comb begin
    w_slv_ready = 1'b1;
    w_slv_resp  = HRESP_OKAY;
    w_slv_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_idx == 4'(i)) begin
        w_slv_ready = HREADY_S[i];
        w_slv_resp  = HRESP_S[i];
        w_slv_rdata = HRDATA_S[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    HREADY = 1'b1;
    HRESP  = HRESP_OKAY;
    HRDATA = '0;
    case (r_owner)
      OWN_SLV: begin
        HREADY = w_slv_ready;
        HRESP  = w_slv_resp;
        HRDATA = w_slv_rdata;
      end
      OWN_DEF: begin
        HREADY = w_def_ready;
        HRESP  = w_def_resp;
      end
      default: ;
    endcase
  end

  assign w_stall     = (r_owner == OWN_SLV) && !w_slv_ready;
  assign w_abort     = w_stall && (TIMEOUT != 0) && (r_wd_cnt == CW'(TIMEOUT - 1));
  assign w_def_start = (HREADY && w_active && !w_dec_hit) || w_abort;

  ahblite_default_slave u_def (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .start     (w_def_start),
    .HREADY    (HREADY),
    .HREADYOUT (w_def_ready),
    .HRESP     (w_def_resp)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_owner    <= OWN_NONE;
      r_idx      <= '0;
      r_wd_cnt   <= '0;
      r_to_flag  <= 1'b0;
      r_to_slave <= '0;
    end else begin
      if (w_abort) begin
        // the hung slave loses the data phase; the default slave finishes it
        r_owner  <= OWN_DEF;
        r_wd_cnt <= '0;
      end else if (HREADY) begin
        r_wd_cnt <= '0;
        if (w_dec_hit) begin
          r_owner <= OWN_SLV;
          r_idx   <= w_dec_idx;
        end else if (w_active) begin
          r_owner <= OWN_DEF;
        end else begin
          r_owner <= OWN_NONE;
        end
      end else if (w_stall && (TIMEOUT != 0)) begin
        r_wd_cnt <= r_wd_cnt + 1'b1;
      end

      if (w_abort) begin
        r_to_flag  <= 1'b1;
        r_to_slave <= r_idx;
      end else if (to_clr) begin
        r_to_flag <= 1'b0;
      end
    end
  end

  assign to_flag  = r_to_flag;
  assign to_slave = r_to_slave;

endmodule

// File: tb/tb_ahblite_bus_n.sv
// Self-checking bench for ahblite_bus_n: behavioural slaves with programmable
// wait states, transfers scored through an expected-result queue.
module tb_ahblite_bus_n;
  import ahb_pkg::*;

  localparam int NS = 6;
  localparam logic [NS*8-1:0] BASES = {8'h50, 8'h40, 8'h00, 8'h20, 8'h10, 8'h00};
  localparam logic [31:0] IDLE_ADDR = 32'hF000_0000;

  logic              HCLK = 1'b0;
  logic              HRESETn;
  logic [31:0]       HADDR;
  logic [1:0]        HTRANS;
  logic              HREADY;
  logic [31:0]       HRDATA;
  logic              HRESP;
  logic [NS-1:0]     HSEL_S;
  logic [NS-1:0]     HREADY_S;
  logic [NS*32-1:0]  HRDATA_S;
  logic [NS-1:0]     HRESP_S;
  logic              to_flag;
  logic [3:0]        to_slave;
  logic              to_clr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 HCLK = ~HCLK;

  ahblite_bus_n #(
    .NUM_SLAVES (NS),
    .DEC_MSB    (31),
    .DEC_LSB    (24),
    .SLAVE_BASES(BASES),
    .TIMEOUT    (8)
  ) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .HADDR    (HADDR),
    .HTRANS   (HTRANS),
    .HREADY   (HREADY),
    .HRDATA   (HRDATA),
    .HRESP    (HRESP),
    .HSEL_S   (HSEL_S),
    .HREADY_S (HREADY_S),
    .HRDATA_S (HRDATA_S),
    .HRESP_S  (HRESP_S),
    .to_flag  (to_flag),
    .to_slave (to_slave),
    .to_clr   (to_clr)
  );

  // behavioural slaves
  logic [NS-1:0] pend;
  int            cnt    [NS];
  int            s_wait [NS];
  bit            s_hang [NS];
  logic [31:0]   s_data [NS];

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < NS; i++) begin
        pend[i] <= 1'b0;
        cnt[i]  <= 0;
      end
    end else begin
      for (int i = 0; i < NS; i++) begin
        if (HREADY && HSEL_S[i] && HTRANS[1]) begin
          pend[i] <= 1'b1;
          cnt[i]  <= s_wait[i];
        end else if (pend[i] && HREADY_S[i]) begin
          pend[i] <= 1'b0;
        end else if (pend[i] && cnt[i] > 0) begin
          cnt[i] <= cnt[i] - 1;
        end
      end
    end
  end

  always_comb begin
    HREADY_S = '0;
    HRDATA_S = '0;
    HRESP_S  = '0;
    for (int i = 0; i < NS; i++) begin
      HREADY_S[i]          = !pend[i] || (!s_hang[i] && cnt[i] == 0);
      HRDATA_S[i*32 +: 32] = s_data[i];
    end
  end

  typedef struct {
    logic [31:0] data;
    logic        resp;
    int          waits;
  } exp_t;

  exp_t sb[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // one non-pipelined transfer: address phase, then collect the data phase
  task automatic xfer(input string tag, input logic [31:0] a, input logic [1:0] t,
                      input logic [NS-1:0] esel, input int ew,
                      input logic [31:0] ed, input logic er);
    exp_t        e;
    int          w;
    logic        lr, rs, hr;
    logic [31:0] rd;
    bit          done;
    @(negedge HCLK);
    HADDR  = a;
    HTRANS = t;
    #1;
    check_val({tag, "_sel"}, 32'(HSEL_S), 32'(esel));
    e.data = ed; e.resp = er; e.waits = ew;
    sb.push_back(e);
    w = 0; lr = 1'b0; rs = 1'b0; rd = '0; hr = 1'b0; done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge HCLK);
      hr = HREADY; rs = HRESP; rd = HRDATA;
      if (c == 0) begin
        HTRANS = HTRANS_IDLE;
        HADDR  = IDLE_ADDR;
      end
      if (hr) begin
        done = 1'b1;
        break;
      end
      lr = rs;
      w++;
    end
    check_val({tag, "_done"}, 32'(done), 32'd1);
    e = sb.pop_front();
    check_val({tag, "_data"}, rd, e.data);
    check_val({tag, "_resp"}, 32'(rs), 32'(e.resp));
    check_val({tag, "_waits"}, 32'(w), 32'(e.waits));
    if (e.waits > 0) check_val({tag, "_waitresp"}, 32'(lr), 32'(e.resp));
    $display("[TB] xfer %s addr=%h htrans=%0d waits=%0d data=%h resp=%0d", tag, a, t, w, rd, rs);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < NS; i++) begin
      s_wait[i] = 0;
      s_hang[i] = 1'b0;
      s_data[i] = 32'hA5A5_0000 + 32'(i);
    end
    s_data[1] = 32'hCAFE_F00D;
    HRESETn = 1'b0;
    HADDR   = IDLE_ADDR;
    HTRANS  = HTRANS_IDLE;
    to_clr  = 1'b0;
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    check_val("rst_hready", 32'(HREADY), 32'd1);
    check_val("rst_hresp", 32'(HRESP), 32'd0);
    check_val("rst_hrdata", HRDATA, 32'd0);
    check_val("rst_hsel", 32'(HSEL_S), 32'd0);
    check_val("rst_to_flag", 32'(to_flag), 32'd0);
    check_val("rst_to_slave", 32'(to_slave), 32'd0);

    s_wait[1] = 2;
    xfer("s1_read", 32'h1000_0004, HTRANS_NONSEQ, 6'b000010, 2, 32'hCAFE_F00D, HRESP_OKAY);

    xfer("unmapped", 32'hF000_0000, HTRANS_NONSEQ, 6'b000000, 1, 32'h0, HRESP_ERROR);
    xfer("unmapped_idle", 32'hF000_0000, HTRANS_IDLE, 6'b000000, 0, 32'h0, HRESP_OKAY);

    // one stall short of the watchdog limit must complete normally
    s_wait[1] = 7;
    xfer("s1_7wait", 32'h1000_0000, HTRANS_SEQ, 6'b000010, 7, 32'hCAFE_F00D, HRESP_OKAY);
    check_val("no_abort_flag", 32'(to_flag), 32'd0);

    s_hang[2] = 1'b1;
    xfer("s2_hang", 32'h2000_0000, HTRANS_NONSEQ, 6'b000100, 9, 32'h0, HRESP_ERROR);
    check_val("abort_flag", 32'(to_flag), 32'd1);
    check_val("abort_slave", 32'(to_slave), 32'd2);
    s_hang[2] = 1'b0;
    @(negedge HCLK);
    to_clr = 1'b1;
    @(negedge HCLK);
    to_clr = 1'b0;
    #1;
    check_val("clr_flag", 32'(to_flag), 32'd0);
    check_val("clr_keep_slave", 32'(to_slave), 32'd2);

    xfer("dup_base", 32'h0000_0000, HTRANS_NONSEQ, 6'b000001, 0, 32'hA5A5_0000, HRESP_OKAY);
    s_wait[5] = 1;
    xfer("s5_read", 32'h5000_0010, HTRANS_NONSEQ, 6'b100000, 1, 32'hA5A5_0005, HRESP_OKAY);

    // reset in the middle of a slave-4 wait state
    s_wait[4] = 5;
    @(negedge HCLK);
    HADDR  = 32'h4000_0000;
    HTRANS = HTRANS_NONSEQ;
    @(negedge HCLK);
    HTRANS = HTRANS_IDLE;
    HADDR  = IDLE_ADDR;
    check_val("s4_stall", 32'(HREADY), 32'd0);
    @(negedge HCLK);
    #2;
    HRESETn = 1'b0;
    #1;
    check_val("midrst_hready", 32'(HREADY), 32'd1);
    check_val("midrst_hresp", 32'(HRESP), 32'd0);
    check_val("midrst_hrdata", HRDATA, 32'd0);
    $display("[TB] xfer midrst addr=40000000 reset asserted during wait state");
    @(negedge HCLK);
    HRESETn = 1'b1;
    s_wait[4] = 1;
    xfer("post_rst", 32'h4000_0000, HTRANS_NONSEQ, 6'b010000, 1, 32'hA5A5_0004, HRESP_OKAY);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
